rr_arb_mux: RTL and testbench

//  N-channel, W-bit successor to the 8-bit 2:1 select mux.

---
 rtl/mux_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 65 ++++++
 rtl/rr_arb_mux.sv | 106 ++++++++++
 tb/tb_rr_arb_mux.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin arbitrating mux.
package mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Ceiling log2 with a floor of 1 so a select field is never zero-width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant logic: one-hot grant plus binary index over a request vector,
// either lowest-index-wins or rotating priority starting at ptr.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N    = 2,
  parameter int MODE = MODE_RR
) (
  input  logic [N-1:0]           req,
  input  logic [clog2(N)-1:0]    ptr,
  output logic [N-1:0]           gnt,
  output logic [clog2(N)-1:0]    gnt_idx
);

  localparam int SEL_W = clog2(N);
  // One spare bit so the distance i+N-ptr never overflows for non-power-of-two N.
  localparam int DW    = SEL_W + 1;

  logic [DW-1:0] ptr_ext_s;
  logic [DW-1:0] dist_s [N];
  logic [DW-1:0] best_s;
  logic          found_s;

  assign ptr_ext_s = {1'b0, ptr};

  // Priority distance of each channel: rotated from ptr in RR mode, plain index otherwise.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (MODE == MODE_RR) begin
        if (DW'(i) >= ptr_ext_s) begin
          dist_s[i] = DW'(i) - ptr_ext_s;
        end else begin
          dist_s[i] = DW'(i) + DW'(N) - ptr_ext_s;
        end
      end else begin
        dist_s[i] = DW'(i);
      end
    end
  end

  // Pick the requesting channel with the smallest distance.
  always_comb begin
    best_s  = {DW{1'b1}};
    gnt_idx = {SEL_W{1'b0}};
    found_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (dist_s[i] < best_s)) begin
        best_s  = dist_s[i];
        gnt_idx = SEL_W'(i);
        found_s = 1'b1;
      end else begin
        best_s  = best_s;
      end
    end
  end

  // Expand the winning index to a one-hot grant; zero when nothing requests.
  always_comb begin
    gnt = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      gnt[i] = found_s && (gnt_idx == SEL_W'(i));
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel valid/ready arbitrating mux with a registered output stage.
// Holds the round-robin pointer, the output register and the data select.
module rr_arb_mux
  import mux_pkg::*;
#(
  parameter int W    = 8,
  parameter int N    = 2,
  parameter int MODE = MODE_RR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           in_valid,
  output logic [N-1:0]           in_ready,
  input  logic [N*W-1:0]         in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_data,
  output logic [clog2(N)-1:0]    out_sel
);

  localparam int SEL_W = clog2(N);

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  logic             can_acc_s;
  logic             xfer_s;
  logic [N-1:0]     gnt_s;
  logic [SEL_W-1:0] gnt_idx_s;
  logic [W-1:0]     sel_data_s;

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  // The output stage can take a beat when empty or draining this cycle.
  assign can_acc_s = !out_valid_q || out_ready;
  assign in_ready  = gnt_s & {N{can_acc_s}};
  assign xfer_s    = |(in_valid & in_ready);

  // AND-OR data select over the one-hot grant.
  always_comb begin
    sel_data_s = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      sel_data_s = sel_data_s | (in_data[i*W +: W] & {W{gnt_s[i]}});
    end
  end

  // Output stage next state: load on transfer, drop valid when drained, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data_s;
      out_sel_d   = gnt_idx_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pointer moves to the channel after the winner, wrapping explicitly at N-1.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer_s && (MODE == MODE_RR)) begin
      if (gnt_idx_s == SEL_W'(N - 1)) begin
        ptr_d = {SEL_W{1'b0}};
      end else begin
        ptr_d = gnt_idx_s + SEL_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers; reset discards any held beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {W{1'b0}};
      out_sel_q   <= {SEL_W{1'b0}};
      ptr_q       <= {SEL_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: three instances (N=2 RR, N=2 fixed, N=3 RR).
module tb_rr_arb_mux;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;

  // Instance A: N=2, W=8, round-robin
  logic [1:0]  a_in_valid = 2'b00;
  logic [1:0]  a_in_ready;
  logic [15:0] a_in_data = 16'h0000;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  logic [7:0]  a_out_data;
  logic [0:0]  a_out_sel;

  // Instance B: N=2, W=8, fixed priority
  logic [1:0]  b_in_valid = 2'b00;
  logic [1:0]  b_in_ready;
  logic [15:0] b_in_data = 16'h0000;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [7:0]  b_out_data;
  logic [0:0]  b_out_sel;

  // Instance C: N=3, W=8, round-robin
  logic [2:0]  c_in_valid = 3'b000;
  logic [2:0]  c_in_ready;
  logic [23:0] c_in_data = 24'h000000;
  logic        c_out_valid;
  logic        c_out_ready = 1'b0;
  logic [7:0]  c_out_data;
  logic [1:0]  c_out_sel;

  rr_arb_mux #(.W(8), .N(2), .MODE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_sel(a_out_sel));

  rr_arb_mux #(.W(8), .N(2), .MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_sel(b_out_sel));

  rr_arb_mux #(.W(8), .N(3), .MODE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_sel(c_out_sel));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    a_in_valid = 2'b01; a_in_data = {8'hBB, 8'hAA}; a_out_ready = 1'b0;
    tick();
    tests_run++; if (a_out_valid !== 1'b1 || a_out_data !== 8'hAA) begin tests_failed++; $display("FAIL reset_preload: got v=%b d=%h expected v=1 d=aa", a_out_valid, a_out_data); end
    a_in_valid = 2'b00;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", a_out_valid); end
    tests_run++; if (a_out_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", a_out_data); end
    tests_run++; if (a_out_sel !== 1'b0) begin tests_failed++; $display("FAIL reset_sel: got %b expected 0", a_out_sel); end
    tests_run++; if (a_in_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 00", a_in_ready); end
    tests_run++; if (b_out_valid !== 1'b0 || c_out_valid !== 1'b0 || c_out_sel !== 2'b00) begin tests_failed++; $display("FAIL reset_others: got bv=%b cv=%b cs=%b expected 0 0 00", b_out_valid, c_out_valid, c_out_sel); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rr_alternate();
    logic [1:0] exp_rdy;
    logic [7:0] exp_d;
    logic       exp_s;
    a_in_data = {8'hBB, 8'hAA}; a_in_valid = 2'b11; a_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_s   = (k % 2 == 1) ? 1'b1 : 1'b0;
      exp_rdy = exp_s ? 2'b10 : 2'b01;
      exp_d   = exp_s ? 8'hBB : 8'hAA;
      @(negedge clk);
      tests_run++; if (a_in_ready !== exp_rdy) begin tests_failed++; $display("FAIL rr_in_ready k=%0d: got %b expected %b", k, a_in_ready, exp_rdy); end
      tick();
      tests_run++; if (a_out_valid !== 1'b1 || a_out_data !== exp_d || a_out_sel !== exp_s) begin tests_failed++; $display("FAIL rr_out k=%0d: got v=%b d=%h s=%b expected v=1 d=%h s=%b", k, a_out_valid, a_out_data, a_out_sel, exp_d, exp_s); end
    end
    a_in_valid = 2'b00;
    tick();
    tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL rr_drain: got %b expected 0", a_out_valid); end
  endtask

  task automatic test_fixed();
    b_in_data = {8'hBB, 8'hAA}; b_in_valid = 2'b11; b_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++; if (b_in_ready !== 2'b01) begin tests_failed++; $display("FAIL fixed_in_ready k=%0d: got %b expected 01", k, b_in_ready); end
      tick();
      tests_run++; if (b_out_valid !== 1'b1 || b_out_data !== 8'hAA || b_out_sel !== 1'b0) begin tests_failed++; $display("FAIL fixed_out k=%0d: got v=%b d=%h s=%b expected v=1 d=aa s=0", k, b_out_valid, b_out_data, b_out_sel); end
    end
    b_in_valid = 2'b00;
    tick();
  endtask

  task automatic test_backpressure();
    a_in_valid = 2'b01; a_in_data = {8'h00, 8'h5A}; a_out_ready = 1'b0;
    tick();
    tests_run++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h5A || a_out_sel !== 1'b0) begin tests_failed++; $display("FAIL bp_load: got v=%b d=%h s=%b expected v=1 d=5a s=0", a_out_valid, a_out_data, a_out_sel); end
    a_in_data = {8'h00, 8'hC3};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++; if (a_in_ready !== 2'b00) begin tests_failed++; $display("FAIL bp_in_ready k=%0d: got %b expected 00", k, a_in_ready); end
      tests_run++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h5A) begin tests_failed++; $display("FAIL bp_hold k=%0d: got v=%b d=%h expected v=1 d=5a", k, a_out_valid, a_out_data); end
      tick();
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (a_in_ready !== 2'b01) begin tests_failed++; $display("FAIL bp_release_ready: got %b expected 01", a_in_ready); end
    tick();
    tests_run++; if (a_out_valid !== 1'b1 || a_out_data !== 8'hC3 || a_out_sel !== 1'b0) begin tests_failed++; $display("FAIL bp_next: got v=%b d=%h s=%b expected v=1 d=c3 s=0", a_out_valid, a_out_data, a_out_sel); end
    a_in_valid = 2'b00;
    tick();
    tests_run++; if (a_out_valid !== 1'b0 || a_out_data !== 8'hC3) begin tests_failed++; $display("FAIL bp_idle_hold: got v=%b d=%h expected v=0 d=c3", a_out_valid, a_out_data); end
  endtask

  task automatic test_n3_rr();
    logic [1:0] order [4];
    logic [1:0] exp_s;
    logic [7:0] exp_d;
    logic [2:0] exp_rdy;
    order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd0; order[3] = 2'd1;
    c_in_data = {8'h32, 8'h21, 8'h10}; c_out_ready = 1'b1;
    c_in_valid = 3'b010;
    tick();
    tests_run++; if (c_out_sel !== 2'd1 || c_out_data !== 8'h21) begin tests_failed++; $display("FAIL n3_setup: got s=%0d d=%h expected s=1 d=21", c_out_sel, c_out_data); end
    c_in_valid = 3'b001;
    @(negedge clk);
    tests_run++; if (c_in_ready !== 3'b001) begin tests_failed++; $display("FAIL n3_lone_ready: got %b expected 001", c_in_ready); end
    tick();
    tests_run++; if (c_out_valid !== 1'b1 || c_out_sel !== 2'd0 || c_out_data !== 8'h10) begin tests_failed++; $display("FAIL n3_lone_out: got v=%b s=%0d d=%h expected v=1 s=0 d=10", c_out_valid, c_out_sel, c_out_data); end
    c_in_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      exp_s = order[k];
      case (exp_s)
        2'd0:    exp_d = 8'h10;
        2'd1:    exp_d = 8'h21;
        2'd2:    exp_d = 8'h32;
        default: exp_d = 8'hXX;
      endcase
      exp_rdy = 3'b001 << exp_s;
      @(negedge clk);
      tests_run++; if (c_in_ready !== exp_rdy) begin tests_failed++; $display("FAIL n3_ready k=%0d: got %b expected %b", k, c_in_ready, exp_rdy); end
      tick();
      tests_run++; if (c_out_valid !== 1'b1 || c_out_sel !== exp_s || c_out_data !== exp_d) begin tests_failed++; $display("FAIL n3_order k=%0d: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h", k, c_out_valid, c_out_sel, c_out_data, exp_s, exp_d); end
    end
    c_in_valid = 3'b000;
    @(negedge clk);
    tests_run++; if (c_in_ready !== 3'b000) begin tests_failed++; $display("FAIL n3_none_ready: got %b expected 000", c_in_ready); end
    tick();
    tests_run++; if (c_out_valid !== 1'b0) begin tests_failed++; $display("FAIL n3_idle: got %b expected 0", c_out_valid); end
  endtask

  task automatic test_reset_midxfer();
    a_in_valid = 2'b01; a_in_data = {8'hEE, 8'h77}; a_out_ready = 1'b0;
    tick();
    a_in_valid = 2'b00;
    @(negedge clk);
    tests_run++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h77) begin tests_failed++; $display("FAIL mid_held: got v=%b d=%h expected v=1 d=77", a_out_valid, a_out_data); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (a_out_valid !== 1'b0 || a_out_data !== 8'h00 || a_out_sel !== 1'b0) begin tests_failed++; $display("FAIL mid_reset: got v=%b d=%h s=%b expected v=0 d=00 s=0", a_out_valid, a_out_data, a_out_sel); end
    tick();
    rst_n = 1'b1;
    a_in_valid = 2'b11; a_out_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (a_in_ready !== 2'b01) begin tests_failed++; $display("FAIL mid_first_grant: got %b expected 01", a_in_ready); end
    tick();
    tests_run++; if (a_out_valid !== 1'b1 || a_out_sel !== 1'b0 || a_out_data !== 8'h77) begin tests_failed++; $display("FAIL mid_first_out: got v=%b s=%b d=%h expected v=1 s=0 d=77", a_out_valid, a_out_sel, a_out_data); end
    a_in_valid = 2'b00;
    tick();
    tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_no_replay: got %b expected 0", a_out_valid); end
  endtask

  initial begin
    test_reset();
    test_rr_alternate();
    test_fixed();
    test_backpressure();
    test_n3_rr();
    test_reset_midxfer();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
